// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic interstage pipeline register with valid/ready handshake,
//            2-entry skid buffer (registered upstream ready), stall and flush.
//            A flush leaves a bubble whose control field is zero.
// Options  : `define PIPE_STAGE_REG_BUBBLE_CNT_EN adds a saturating 16-bit
//            counter of output bubble cycles (out_valid=0 and stall=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              reset_n,   // active-high asynchronous reset
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
  output logic [15:0]       bubble_cnt,
`endif
  output logic [1:0]        occ
);

  // Occupancy doubles as the state: main entry valid in ONE/TWO, skid in TWO.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   w_main_ctrl_nxt;
  logic [DATA_W-1:0]   w_main_data_nxt;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic                w_enq;
  logic                w_deq;

  assign w_enq = in_valid & r_in_ready;
  assign w_deq = r_out_valid & out_ready & ~stall;

  // Next-state and storage steering; flush overrides every other action.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (flush) begin
      // Bubble: control zeroed so no RegWrite/MemWrite escapes; data kept.
      w_state_nxt     = S_EMPTY;
      w_main_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_enq) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
            w_state_nxt     = S_ONE;
          end
        end
        S_ONE: begin
          if (w_enq && w_deq) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_enq) begin
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
            w_state_nxt     = S_TWO;
          end else if (w_deq) begin
            w_main_ctrl_nxt = '0;
            w_state_nxt     = S_EMPTY;
          end
        end
        S_TWO: begin
          // Upstream ready is low here, so only a dequeue can happen.
          if (w_deq) begin
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = '0;
            w_state_nxt     = S_ONE;
          end
        end
        default: begin
          w_main_ctrl_nxt = '0;
          w_skid_ctrl_nxt = '0;
          w_state_nxt     = S_EMPTY;
        end
      endcase
    end
  end

  // State, storage and registered handshake outputs.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occ       = r_state;

`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  // Saturating count of unstalled cycles with no valid output; flush keeps it.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_bubble_cnt <= '0;
    end else if (!r_out_valid && !stall && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised interstage pipeline register for the RISC-V core; replaces the fixed-width per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a control field and a data field with a valid/ready handshake.
- Includes a 2-entry skid buffer, so upstream ready is a registered signal and no combinational ready path spans stages.
- Supports stall and flush; a flush inserts a bubble whose control bits are zeroed, so RegWrite and MemWrite are forced to 0.

Parameters:
- CTRL_W, 4, width of the control field (RegWrite, Mem2Reg, ...); zeroed on flush and reset.
- DATA_W, 69, width of the data field (results, destination register); zeroed on reset only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-high reset (asserted = 1, despite the name).
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  block can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- stall  in  1  downstream hazard stall; blocks dequeue.
- flush  in  1  kill all held entries and the incoming entry (branch/jump redirect).
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control field; all zeros when out_valid=0.
- out_data  out  DATA_W  head data field.
- occ  out  2  occupancy, 0..2.

Behaviour:
- Storage: main entry (head, drives outputs) and skid entry, each with a valid bit. All outputs are registered.
- Handshake terms:
  - enq = in_valid & in_ready.
  - deq = out_valid & out_ready & ~stall.
- Reset (async, reset_n=1): both valid bits 0; out_ctrl=0; out_data=0; occ=0; in_ready=1. The first accept is possible on the first posedge after reset deasserts.
- in_ready is registered: 1 iff the skid entry is empty.
- States by occ:
  - EMPTY (0): enq loads main. Next state ONE. Latency in -> out is 1 cycle.
  - ONE (1):
    - enq & deq: main <= input; stay ONE.
    - enq & ~deq: skid <= input; go TWO; in_ready drops next cycle.
    - ~enq & deq: go EMPTY.
  - TWO (2): in_ready=0, so no enq. On deq, main <= skid and go ONE; in_ready=1 next cycle.
- Ordering: strict FIFO. An entry never bypasses an older one.
- Stall: deq is blocked; outputs hold stable. Enqueue continues while space remains, filling the skid entry at most.
- Flush:
  - Takes priority over everything.
  - Next cycle: both valid bits 0, occ=0, out_ctrl=0, in_ready=1.
  - The input offered in the flush cycle is discarded even if enq=1.
  - out_data is not cleared.
- flush & stall together: flush wins.
- Simultaneous enq and deq at occ=1: counts as a pass-through; occ is unchanged.
- Reset asserted mid-transfer: held entries are lost immediately (asynchronous); no partial updates.
- Invalid-output rule: out_ctrl reads 0 whenever out_valid=0, so a bubble can never write the register file.

Optional Feature:
- Macro: PIPE_STAGE_REG_BUBBLE_CNT_EN.
- Defined:
  - Adds output bubble_cnt [15:0]: counts cycles with out_valid=0 and stall=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset; flush does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with reset_n=1 mid-cycle, with in_valid=1, in_ctrl=4'b1011, in_data=500 applied -> immediately out_valid=0, out_ctrl=0, out_data=0, occ=0, in_ready=1. After release, one posedge -> out_ctrl=4'b1011, out_data=500.
- Streaming: out_ready=1, entries 100, 200, 300 on consecutive cycles -> outputs appear 1 cycle later in order; occ stays 1; in_ready stays 1.
- Skid fill: out_ready=0, enqueue 10 then 20 -> occ=2 and in_ready=0; third entry 30 is held upstream. Raise out_ready -> outputs 10, 20, 30 in order with no loss or duplication.
- Stall: occ=1 holding 7, out_ready=1, stall=1 for 3 cycles -> out_data=7 stable; entry 8 goes to skid (occ=2). Stall=0 -> 7 then 8.
- Flush: occ=2, flush=1 together with enq of 55 -> next cycle occ=0, out_valid=0, out_ctrl=0, in_ready=1; 55 never appears.
- With PIPE_STAGE_REG_BUBBLE_CNT_EN: idle 5 cycles after reset -> bubble_cnt=5. Preload 16'hFFFE, idle 3 cycles -> bubble_cnt=16'hFFFF.
